uart_tx_frame: RTL and testbench



---
 rtl/uart_defs.sv | 22 ++
 rtl/uart_word_shifter.sv | 47 ++++
 rtl/uart_tx_frame.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared definitions for the multi-word UART transmitter: FSM state encoding,
// parity modes and the number of line cycles one word occupies.
package uart_defs;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4,
      FIN   = 3'd5
   } state_e;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   function automatic int word_cycles(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_word_shifter.sv
// Holds one data word and presents it bit by bit, MSB- or LSB-first, together
// with the parity bit of the loaded word.
module uart_word_shifter
   import uart_defs::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PARITY_NONE,
   parameter int MSB_FIRST = 1
) (
   input  logic                 clk_19k2,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 shift,
   input  logic [DATA_BITS-1:0] load_word,
   output logic                 head_bit,
   output logic                 parity_bit
);

   logic [DATA_BITS-1:0] shreg_q, shreg_d;

   always_ff @(posedge clk_19k2 or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   // Rotate rather than shift in zeros: the register always holds a permutation
   // of the loaded word, so its XOR stays equal to the word's parity.
   always_comb begin
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = load_word;
      end else if (shift) begin
         if (MSB_FIRST != 0) begin
            shreg_d = {shreg_q[DATA_BITS-2:0], shreg_q[DATA_BITS-1]};
         end else begin
            shreg_d = {shreg_q[0], shreg_q[DATA_BITS-1:1]};
         end
      end
   end

   assign head_bit   = (MSB_FIRST != 0) ? shreg_q[DATA_BITS-1] : shreg_q[0];
   assign parity_bit = (PARITY == PARITY_EVEN) ? (^shreg_q) : (~^shreg_q);

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-word UART transmitter running at one line bit per clk_19k2 cycle.
// The whole frame is latched on the request edge and sent back to back.
module uart_tx_frame
   import uart_defs::*;
#(
   parameter int NUM_BYTES = 5,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = PARITY_NONE,
   parameter int STOP_BITS = 1,
   parameter int MSB_FIRST = 1
) (
   input  logic                           clk_19k2,
   input  logic                           rst,
   input  logic                           send_req,
   input  logic [NUM_BYTES*DATA_BITS-1:0] frame_data,
   output logic                           busy,
   output logic                           done,
   output logic                           uart_out
);

   localparam int                BIT_W      = $clog2(DATA_BITS + 1);
   localparam int                BYTE_W     = $clog2(NUM_BYTES + 1);
   localparam int                WORD_SLOTS = 2 ** BYTE_W;
   localparam logic [BIT_W-1:0]  LAST_BIT   = BIT_W'(DATA_BITS);
   localparam logic [BYTE_W-1:0] LAST_BYTE  = BYTE_W'(NUM_BYTES - 1);
   localparam logic              LAST_STOP  = (STOP_BITS == 2);

   state_e                         state_q, state_d;
   logic                           req_q;
   logic [NUM_BYTES*DATA_BITS-1:0] frame_q, frame_d;
   logic [BIT_W-1:0]               bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]              byte_cnt_q, byte_cnt_d;
   logic                           stop_cnt_q, stop_cnt_d;
   logic                           uart_out_q, uart_out_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;

   logic                 start_det, last_stop, more_words, last_data;
   logic                 sh_load, sh_shift, head_bit, parity_bit;
   logic [BYTE_W-1:0]    next_idx;
   logic [DATA_BITS-1:0] load_word;
   logic [DATA_BITS-1:0] word_slot [WORD_SLOTS];

   // Power-of-two slot table so byte_cnt can index it without width tricks.
   for (genvar gi = 0; gi < WORD_SLOTS; gi++) begin : g_word_slot
      if (gi < NUM_BYTES) begin : g_used
         assign word_slot[gi] = frame_q[gi*DATA_BITS +: DATA_BITS];
      end else begin : g_unused
         assign word_slot[gi] = '0;
      end
   end

   assign start_det  = (state_q == IDLE) && send_req && !req_q;
   assign last_data  = (state_q == DATA) && (bit_cnt_q == LAST_BIT);
   assign last_stop  = (state_q == STOP) && (stop_cnt_q == LAST_STOP);
   assign more_words = (byte_cnt_q != LAST_BYTE);
   assign next_idx   = byte_cnt_q + BYTE_W'(1);

   assign sh_load   = start_det || (last_stop && more_words);
   assign sh_shift  = (state_q == DATA) && !last_data;
   assign load_word = start_det ? frame_data[DATA_BITS-1:0] : word_slot[next_idx];

   uart_word_shifter #(
      .DATA_BITS (DATA_BITS),
      .PARITY    (PARITY),
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clk_19k2   (clk_19k2),
      .rst        (rst),
      .load       (sh_load),
      .shift      (sh_shift),
      .load_word  (load_word),
      .head_bit   (head_bit),
      .parity_bit (parity_bit)
   );

   always_ff @(posedge clk_19k2 or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         req_q      <= 1'b1;
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         stop_cnt_q <= 1'b0;
         uart_out_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= send_req;
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         uart_out_q <= uart_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // START is never entered: the start bit is driven on the detect edge itself.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_det) state_d = DATA;
         DATA: if (last_data) state_d = (PARITY != PARITY_NONE) ? PAR : STOP;
         PAR:  state_d = STOP;
         STOP: if (last_stop) state_d = more_words ? DATA : FIN;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      frame_d    = frame_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      stop_cnt_d = stop_cnt_q;
      uart_out_d = uart_out_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            uart_out_d = 1'b1;
            if (start_det) begin
               frame_d    = frame_data;
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
               uart_out_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         DATA: begin
            if (last_data) begin
               // First post-data bit: parity, or the first stop bit.
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               uart_out_d = (PARITY != PARITY_NONE) ? parity_bit : 1'b1;
            end else begin
               bit_cnt_d  = bit_cnt_q + BIT_W'(1);
               uart_out_d = head_bit;
            end
         end
         PAR: begin
            stop_cnt_d = 1'b0;
            uart_out_d = 1'b1;
         end
         STOP: begin
            if (last_stop) begin
               stop_cnt_d = 1'b0;
               if (more_words) begin
                  byte_cnt_d = next_idx;
                  uart_out_d = 1'b0;
               end else begin
                  uart_out_d = 1'b1;
                  busy_d     = 1'b0;
               end
            end else begin
               stop_cnt_d = 1'b1;
               uart_out_d = 1'b1;
            end
         end
         FIN: begin
            uart_out_d = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            byte_cnt_d = '0;
         end
         default: begin
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            stop_cnt_d = 1'b0;
            uart_out_d = 1'b1;
            busy_d     = 1'b0;
         end
      endcase
   end

   assign uart_out = uart_out_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench: four transmitter configurations, a constant vector table,
// randomized frames against a bit-list reference model, and hand-written corners.
module tb_uart_tx_frame;
   import uart_defs::*;

   localparam int NB  [4] = '{5, 1, 1, 1};
   localparam int PAR [4] = '{PARITY_NONE, PARITY_EVEN, PARITY_ODD, PARITY_NONE};
   localparam int STP [4] = '{1, 1, 1, 2};
   localparam int MSB [4] = '{1, 1, 1, 0};

   logic        clk_19k2 = 1'b0;
   logic        rst;
   logic        req   [4];
   logic [39:0] fdata [4];
   logic        bsy   [4];
   logic        dn    [4];
   logic        line  [4];

   int checks = 0;
   int errors = 0;
   bit exp_q[$];
   bit obs_q[$];

   always #5 clk_19k2 = ~clk_19k2;

   uart_tx_frame #(.NUM_BYTES(NB[0]), .DATA_BITS(8), .PARITY(PAR[0]), .STOP_BITS(STP[0]), .MSB_FIRST(MSB[0])) dut0 (
      .clk_19k2(clk_19k2), .rst(rst), .send_req(req[0]), .frame_data(fdata[0]),
      .busy(bsy[0]), .done(dn[0]), .uart_out(line[0]));
   uart_tx_frame #(.NUM_BYTES(NB[1]), .DATA_BITS(8), .PARITY(PAR[1]), .STOP_BITS(STP[1]), .MSB_FIRST(MSB[1])) dut1 (
      .clk_19k2(clk_19k2), .rst(rst), .send_req(req[1]), .frame_data(fdata[1][7:0]),
      .busy(bsy[1]), .done(dn[1]), .uart_out(line[1]));
   uart_tx_frame #(.NUM_BYTES(NB[2]), .DATA_BITS(8), .PARITY(PAR[2]), .STOP_BITS(STP[2]), .MSB_FIRST(MSB[2])) dut2 (
      .clk_19k2(clk_19k2), .rst(rst), .send_req(req[2]), .frame_data(fdata[2][7:0]),
      .busy(bsy[2]), .done(dn[2]), .uart_out(line[2]));
   uart_tx_frame #(.NUM_BYTES(NB[3]), .DATA_BITS(8), .PARITY(PAR[3]), .STOP_BITS(STP[3]), .MSB_FIRST(MSB[3])) dut3 (
      .clk_19k2(clk_19k2), .rst(rst), .send_req(req[3]), .frame_data(fdata[3][7:0]),
      .busy(bsy[3]), .done(dn[3]), .uart_out(line[3]));

   typedef struct {
      int          inst;
      logic [39:0] data;
      string       first;      // expected line bits of word 0, in send order
      int          frame_len;  // expected busy cycles
      bit          scramble;
      bit          mid_edge;
      bit          fin_edge;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: the frame as a flat list of line bits built from the framing rules.
   function automatic void model_frame(input int inst, input logic [39:0] data);
      logic [7:0] w;
      exp_q.delete();
      for (int k = 0; k < NB[inst]; k++) begin
         w = data[k*8 +: 8];
         exp_q.push_back(1'b0);
         for (int i = 0; i < 8; i++) exp_q.push_back(w[(MSB[inst] != 0) ? 7 - i : i]);
         if (PAR[inst] == PARITY_EVEN) exp_q.push_back(($countones(w) % 2) == 1);
         if (PAR[inst] == PARITY_ODD)  exp_q.push_back(($countones(w) % 2) == 0);
         for (int s = 0; s < STP[inst]; s++) exp_q.push_back(1'b1);
      end
   endfunction

   task automatic run_frame(input int inst, input logic [39:0] data, input bit scramble,
                            input bit mid_edge, input bit fin_edge,
                            output int busy_cnt, output int done_at);
      int          len;
      int          done_cnt;
      logic [63:0] got_v, exp_v;
      model_frame(inst, data);
      len      = exp_q.size();
      obs_q.delete();
      busy_cnt = 0;
      done_at  = -1;
      done_cnt = 0;
      @(negedge clk_19k2);
      fdata[inst] = data;
      req[inst]   = 1'b1;
      for (int c = 0; c < len + 8; c++) begin
         @(negedge clk_19k2);
         if (c < len) obs_q.push_back(line[inst]);
         if (bsy[inst]) busy_cnt++;
         if (dn[inst]) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (scramble) fdata[inst] = {8'($urandom), $urandom};
         if (mid_edge && c == 5) req[inst] = 1'b0;
         if (mid_edge && c == 6) req[inst] = 1'b1;
         if (fin_edge && c == len - 5) req[inst] = 1'b0;
         if (fin_edge && c == len) req[inst] = 1'b1;
      end
      got_v = '0;
      exp_v = '0;
      for (int i = 0; i < len; i++) begin
         got_v[i] = obs_q[i];
         exp_v[i] = exp_q[i];
      end
      $display("frame inst=%0d data=0x%010h bits=%0d busy=%0d done_at=%0d", inst, data, len, busy_cnt, done_at);
      check($sformatf("line_bits[%0d]", inst), got_v, exp_v);
      check($sformatf("busy_cycles[%0d]", inst), busy_cnt, len);
      check($sformatf("done_cycle[%0d]", inst), done_at, len + 1);
      check($sformatf("done_count[%0d]", inst), done_cnt, 1);
      check($sformatf("idle_line[%0d]", inst), line[inst], 1);
      req[inst] = 1'b0;
   endtask

   initial begin
      int          bc, da, frames, dones;
      logic        prev_busy;
      logic [63:0] fb_got, fb_exp;

      vecs[0] = '{0, 40'h3C00FF01A5, "0101001011",  50, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1, 40'h07,         "00000011111", 11, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{2, 40'h07,         "00000011101", 11, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{3, 40'h01,         "01000000011", 11, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{0, 40'h0000000000, "0000000001",  50, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1, 40'h00,         "00000000001", 11, 1'b0, 1'b1, 1'b1};

      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req[i]   = 1'b0;
         fdata[i] = '0;
      end
      req[0] = 1'b1;
      repeat (3) @(negedge clk_19k2);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset_line[%0d]", i), line[i], 1);
         check($sformatf("reset_busy[%0d]", i), bsy[i], 0);
         check($sformatf("reset_done[%0d]", i), dn[i], 0);
      end
      rst = 1'b0;
      repeat (5) @(negedge clk_19k2);
      check("held_through_reset_busy", bsy[0], 0);
      req[0] = 1'b0;

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v].inst, vecs[v].data, vecs[v].scramble, vecs[v].mid_edge, vecs[v].fin_edge, bc, da);
         fb_got = '0;
         fb_exp = '0;
         for (int i = 0; i < vecs[v].first.len(); i++) begin
            fb_got[i] = obs_q[i];
            fb_exp[i] = (vecs[v].first.getc(i) == 8'h31);
         end
         check($sformatf("vec%0d_word0", v), fb_got, fb_exp);
         check($sformatf("vec%0d_busy_len", v), bc, vecs[v].frame_len);
         check($sformatf("vec%0d_done_at", v), da, vecs[v].frame_len + 1);
      end

      for (int r = 0; r < 12; r++) begin
         run_frame(int'($urandom_range(0, 3)), {8'($urandom), $urandom},
                   1'($urandom), 1'($urandom), 1'($urandom), bc, da);
      end

      // Level held for 200 cycles: one frame only, then a re-arm sends another.
      fdata[0]  = 40'h3C00FF01A5;
      frames    = 0;
      dones     = 0;
      prev_busy = 1'b0;
      @(negedge clk_19k2);
      req[0] = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_19k2);
         if (bsy[0] && !prev_busy) frames++;
         if (dn[0]) dones++;
         prev_busy = bsy[0];
      end
      $display("hold inst=0 frames=%0d dones=%0d", frames, dones);
      check("hold_frames", frames, 1);
      check("hold_dones", dones, 1);
      req[0] = 1'b0;
      run_frame(0, 40'h3C00FF01A5, 1'b0, 1'b0, 1'b0, bc, da);

      // Reset during word 2 with the request held high.
      @(negedge clk_19k2);
      fdata[0] = 40'h123456789A;
      req[0]   = 1'b1;
      repeat (25) @(negedge clk_19k2);
      check("pre_reset_busy", bsy[0], 1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_line", line[0], 1);
      check("async_reset_busy", bsy[0], 0);
      @(negedge clk_19k2);
      rst    = 1'b0;
      frames = 0;
      dones  = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk_19k2);
         if (bsy[0]) frames++;
         if (dn[0]) dones++;
      end
      $display("reset inst=0 busy_cycles=%0d dones=%0d", frames, dones);
      check("after_reset_busy_cycles", frames, 0);
      check("after_reset_dones", dones, 0);
      req[0] = 1'b0;
      run_frame(0, 40'hA55AC33C0F, 1'b1, 1'b0, 1'b0, bc, da);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
